// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO block: register offsets and byte-lane helpers.
package gpio_pkg;

  localparam int unsigned BUS_W   = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned ADEC_W  = 8;

  localparam logic [ADEC_W-1:0] GPIO_LED  = 8'h00;
  localparam logic [ADEC_W-1:0] GPIO_SW   = 8'h04;
  localparam logic [ADEC_W-1:0] GPIO_BTN  = 8'h08;
  localparam logic [ADEC_W-1:0] GPIO_PEND = 8'h0C;
  localparam logic [ADEC_W-1:0] GPIO_MASK = 8'h10;
  localparam logic [ADEC_W-1:0] GPIO_EDGE = 8'h14;

  // Expand the four byte selects into a 32-bit bit mask.
  function automatic logic [BUS_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Replace only the selected byte lanes of old_v with new_v.
  function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_v,
                                                  input logic [BUS_W-1:0] new_v,
                                                  input logic [SEL_W-1:0] sel);
    logic [BUS_W-1:0] m;
    m = lane_mask(sel);
    byte_merge = (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level and flip pulses.
module gpio_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic state_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip_c;

  // Count consecutive cycles the synced input differs from the debounced level; flip at the limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    flip_c  = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        flip_c  = 1'b1;
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o  = state_q;
  assign rise_c_o = flip_c & ~state_q;
  assign fall_c_o = flip_c &  state_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave: LED register, synced switches, debounced buttons with edge-select interrupts.
module wb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned LED_W      = 8,
  parameter int unsigned SW_W       = 8,
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  input  logic               wb_we_i,
  input  logic [BUS_W-1:0]   wb_adr_i,
  input  logic [SEL_W-1:0]   wb_sel_i,
  input  logic [BUS_W-1:0]   wb_dat_i,
  output logic [BUS_W-1:0]   wb_dat_o,
  output logic [LED_W-1:0]   gpio_led,
  input  logic [SW_W-1:0]    gpio_sw,
  input  logic [NUM_BTN-1:0] gpio_btn,
  output logic               irq_o
);

  logic                ack_q;
  logic [BUS_W-1:0]    dat_q;
  logic [LED_W-1:0]    led_q, led_d;
  logic [SW_W-1:0]     sw_s1_q, sw_s2_q;
  logic [NUM_BTN-1:0]  pend_q, pend_d;
  logic [NUM_BTN-1:0]  mask_q, mask_d;
  logic [NUM_BTN-1:0]  edge_sel_q, edge_sel_d;
  logic [NUM_BTN-1:0]  btn_state, btn_rise_c, btn_fall_c;
  logic [NUM_BTN-1:0]  set_c, clr_c;
  logic                access_c, wr_c;
  logic [ADEC_W-1:0]   adr_c;
  logic [BUS_W-1:0]    rd_c;
  logic                adr_unused;

  assign access_c   = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_c       = access_c & wb_we_i;
  assign adr_c      = wb_adr_i[ADEC_W-1:0];
  assign adr_unused = ^wb_adr_i[BUS_W-1:ADEC_W];

  // Per-button debouncers.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    gpio_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (gpio_btn[i]),
      .state_o  (btn_state[i]),
      .rise_c_o (btn_rise_c[i]),
      .fall_c_o (btn_fall_c[i])
    );
  end

  // Register file next state; an interrupt event beats a same-cycle W1C.
  always_comb begin
    led_d      = led_q;
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    clr_c      = '0;
    set_c      = (btn_rise_c & edge_sel_q) | (btn_fall_c & ~edge_sel_q);
    if (wr_c) begin
      case (adr_c)
        GPIO_LED:  led_d      = LED_W'(byte_merge(BUS_W'(led_q), wb_dat_i, wb_sel_i));
        GPIO_PEND: clr_c      = NUM_BTN'(wb_dat_i & lane_mask(wb_sel_i));
        GPIO_MASK: mask_d     = NUM_BTN'(byte_merge(BUS_W'(mask_q), wb_dat_i, wb_sel_i));
        GPIO_EDGE: edge_sel_d = NUM_BTN'(byte_merge(BUS_W'(edge_sel_q), wb_dat_i, wb_sel_i));
        default:   ;
      endcase
    end
    pend_d = (pend_q & ~clr_c) | set_c;
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rd_c = '0;
    case (adr_c)
      GPIO_LED:  rd_c = BUS_W'(led_q);
      GPIO_SW:   rd_c = BUS_W'(sw_s2_q);
      GPIO_BTN:  rd_c = BUS_W'(btn_state);
      GPIO_PEND: rd_c = BUS_W'(pend_q);
      GPIO_MASK: rd_c = BUS_W'(mask_q);
      GPIO_EDGE: rd_c = BUS_W'(edge_sel_q);
      default:   rd_c = '0;
    endcase
  end

  // Bus handshake, read data capture, registers and switch synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
    end else begin
      ack_q      <= access_c;
      if (access_c) dat_q <= rd_c;
      led_q      <= led_d;
      sw_s1_q    <= gpio_sw;
      sw_s2_q    <= sw_s1_q;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
    end
  end

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign gpio_led = led_q;
  assign irq_o    = |(pend_q & mask_q);

endmodule
